ps2_key_cmd_queue: RTL and testbench
====================================

// Module: ps2_key_cmd_queue
// PURPOSE
//  Consumes released-key codes from the PS/2 receiver (one-cycle tick + 8-bit code).
//  Maps them to 3-bit game commands and filters same-command repeats within a holdoff window.
//  Buffers commands in a small FIFO that the tennis game FSM drains over a valid/ready handshake.
//  Unmapped codes are discarded; overflow is flagged (sticky).
// PARAMETERS
//  DEPTH       4          FIFO entries; power of 2, >=2
//  HOLDOFF     2500000    cycles a repeated identical command is suppressed (0 = off)
//  KEY_P1_UP   8'h1D      'W'     -> cmd 3'd0
//  KEY_P1_DN   8'h1B      'S'     -> cmd 3'd1
//  KEY_P2_UP   8'h75      up arrow   -> cmd 3'd2
//  KEY_P2_DN   8'h72      down arrow -> cmd 3'd3
//  KEY_START   8'h29      space   -> cmd 3'd4
//  KEY_PAUSE   8'h4D      'P'     -> cmd 3'd5
// PORTS
//  clk           in   1   system clock, all logic on rising edge
//  rst           in   1   synchronous, active-high reset
//  key_valid     in   1   one-cycle strobe: key holds a released-key code
//  key           in   8   scan code, sampled only when key_valid=1
//  cmd_valid     out  1   FIFO non-empty; cmd is valid
//  cmd_ready     in   1   consumer accepts cmd when cmd_valid & cmd_ready
//  cmd           out  3   head-of-queue command code
//  fifo_count    out  $clog2(DEPTH)+1   entries currently held
//  overflow      out  1   sticky: a mapped, non-suppressed command was dropped on full FIFO
//  clr_overflow  in   1   clears overflow
// BEHAVIOUR
//  Reset:
//   - rst=1 at an edge empties the FIFO and clears all state.
//   - After that edge: cmd_valid=0, cmd=0, fifo_count=0, overflow=0.
//   - Decode stage invalid; holdoff counter=0; last-command register invalid.
//   - Reset mid-stream discards the in-flight decode and all queued entries.
//  Stage 1, decode (registered):
//   - At edge N with key_valid=1: d_cmd <= map(key); d_hit <= key matches one of the 6 codes.
//   - Unmapped key: d_hit=0; nothing further happens for it.
//  Stage 2, filter + push (edge N+1, when d_hit=1):
//   - Suppress when HOLDOFF!=0 & last_valid & d_cmd==last_cmd & hold_cnt!=0.
//   - A suppressed command has no side effects: no reload, no overflow.
//   - Otherwise, if the FIFO has room (or a pop occurs this same edge): write d_cmd.
//   - On a write: last_cmd<=d_cmd, last_valid<=1, hold_cnt<=HOLDOFF.
//   - If the FIFO is full with no pop: drop d_cmd, overflow<=1.
//   - A dropped command does not update last_cmd or hold_cnt.
//  Holdoff counter:
//   - Decrements by 1 per cycle while non-zero; a reload at the same edge wins.
//   - A different command is never suppressed; it reloads the window.
//  FIFO:
//   - First-word fall-through: cmd = mem[rd_ptr]; cmd_valid = (fifo_count!=0).
//   - Pop at an edge where cmd_valid & cmd_ready; cmd_ready is ignored while empty.
//   - Push+pop at the same edge: count unchanged; legal when full (no overflow) and when empty.
//   - Pointers wrap modulo DEPTH.
//   - fifo_count is exact, 0..DEPTH.
//   - cmd and cmd_valid hold stable while cmd_ready=0.
//  Latency:
//   - key_valid at edge N -> cmd_valid=1 after edge N+1, if the FIFO was empty.
//  Back-to-back input:
//   - key_valid on consecutive cycles is accepted; one entry per cycle.
//  overflow:
//   - clr_overflow=1 clears it at the next edge.
//   - A new overflow event at the same edge wins: overflow stays 1.
// TESTING
//  T1 (HOLDOFF=0) key 8'h1D -> cmd_valid high after 2 edges, cmd=0. Pop -> fifo_count=0.
//  T2 keys 8'h1C, 8'hF0, 8'hE0 -> cmd_valid never rises; fifo_count stays 0; overflow=0.
//  T3 (HOLDOFF=8) 8'h75 twice 3 cycles apart -> one entry (cmd=2).
//     Repeat 8'h75 after 10 idle cycles -> second entry.
//     8'h72 one cycle after 8'h75 -> both queued (cmd 2, then 3).
//  T4 (DEPTH=4, cmd_ready=0) push 5 mapped distinct-alternating codes -> fifo_count=4, overflow=1.
//     Head is the first code; clr_overflow -> overflow=0; contents intact.
//  T5 full FIFO, cmd_ready=1 and a new push at the same edge -> count stays 4, overflow=0.
//     Drain order is FIFO order.
//  T6 rst asserted with 3 queued and a decode in flight -> after that edge count=0, cmd_valid=0.
//     The in-flight key never appears.

Source files
------------

// File: rtl/ps2_key_cmd_queue.sv
// Turns released PS/2 key codes into 3-bit game commands and filters fast repeats
// of the same command. Results go into a small first-word-fall-through queue.
module ps2_key_cmd_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned HOLDOFF   = 2500000,
  parameter logic [7:0]  KEY_P1_UP = 8'h1D,
  parameter logic [7:0]  KEY_P1_DN = 8'h1B,
  parameter logic [7:0]  KEY_P2_UP = 8'h75,
  parameter logic [7:0]  KEY_P2_DN = 8'h72,
  parameter logic [7:0]  KEY_START = 8'h29,
  parameter logic [7:0]  KEY_PAUSE = 8'h4D
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       key_valid,
  input  logic [7:0]                 key,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [2:0]                 cmd,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  input  logic                       clr_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          d_hit;
  logic [2:0]    d_cmd;
  logic          last_valid;
  logic [2:0]    last_cmd;
  logic [HW-1:0] hold_cnt;

  logic       map_hit;
  logic [2:0] map_cmd;
  logic       suppress, push_req, full, pop, push, drop;

  always_comb begin
    map_hit = 1'b1;
    map_cmd = 3'd0;
    case (key)
      KEY_P1_UP: map_cmd = 3'd0;
      KEY_P1_DN: map_cmd = 3'd1;
      KEY_P2_UP: map_cmd = 3'd2;
      KEY_P2_DN: map_cmd = 3'd3;
      KEY_START: map_cmd = 3'd4;
      KEY_PAUSE: map_cmd = 3'd5;
      default:   map_hit = 1'b0;
    endcase
  end

  assign cmd_valid = (fifo_count != '0);
  assign cmd       = cmd_valid ? mem[rd_ptr] : 3'd0;
  assign full      = (fifo_count == CW'(DEPTH));
  assign pop       = cmd_valid & cmd_ready;
  assign suppress  = (HOLDOFF != 0) && last_valid && (d_cmd == last_cmd) && (hold_cnt != '0);
  assign push_req  = d_hit & ~suppress;
  // A pop at the same edge frees the slot, so a full queue can still accept.
  assign push      = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_hit      <= 1'b0;
      d_cmd      <= 3'd0;
      last_valid <= 1'b0;
      last_cmd   <= 3'd0;
      hold_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      d_hit <= key_valid & map_hit;
      if (key_valid) d_cmd <= map_cmd;

      if (push) begin
        last_cmd   <= d_cmd;
        last_valid <= 1'b1;
        hold_cnt   <= HW'(HOLDOFF);
        wr_ptr     <= wr_ptr + AW'(1);
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HW'(1);
      end

      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);

      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= d_cmd;
  end

endmodule

// File: tb/tb_ps2_key_cmd_queue.sv
// Scoreboard bench for ps2_key_cmd_queue (DEPTH=4, HOLDOFF=8): expected commands are
// queued as keys are driven and compared in order as the queue is drained.
module tb_ps2_key_cmd_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [7:0] key = 8'h00;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic [2:0] cmd;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       clr_overflow = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [2:0] sb [$];

  ps2_key_cmd_queue #(.DEPTH(4), .HOLDOFF(8)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key(key),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .fifo_count(fifo_count), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is just after a rising edge; the key is sampled at the next edge.
  task automatic applyStimulus(input logic [7:0] k, input bit exp_push, input logic [2:0] exp_cmd);
    key_valid = 1'b1;
    key = k;
    if (exp_push) sb.push_back(exp_cmd);
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int budget = 40;
    logic [2:0] exp;
    cmd_ready = 1'b1;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      if (cmd_valid) begin
        exp = sb.pop_front();
        checkOutput("drain_cmd", 32'(cmd), 32'(exp));
      end
      @(posedge clk); #1;
      budget--;
    end
    cmd_ready = 1'b0;
    if (sb.size() > 0) begin
      checkOutput("drain_timeout", 32'(sb.size()), 0);
      sb.delete();
    end
    @(negedge clk);
    checkOutput("drain_empty", 32'(cmd_valid), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    idle(2);
    @(negedge clk);
    checkOutput("rst_cmd_valid", 32'(cmd_valid), 0);
    checkOutput("rst_cmd", 32'(cmd), 0);
    checkOutput("rst_count", 32'(fifo_count), 0);
    checkOutput("rst_overflow", 32'(overflow), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: latency of two edges into an empty queue
    key_valid = 1'b1; key = 8'h1D;
    @(posedge clk); #1;
    key_valid = 1'b0;
    @(negedge clk);
    checkOutput("t1_not_yet", 32'(cmd_valid), 0);
    @(negedge clk);
    checkOutput("t1_valid", 32'(cmd_valid), 1);
    checkOutput("t1_cmd", 32'(cmd), 0);
    checkOutput("t1_count", 32'(fifo_count), 1);
    @(posedge clk); #1;
    sb.push_back(3'd0);
    drain();

    // T2: unmapped codes leave no trace
    applyStimulus(8'h1C, 0, 3'd0);
    applyStimulus(8'hF0, 0, 3'd0);
    applyStimulus(8'hE0, 0, 3'd0);
    idle(3);
    @(negedge clk);
    checkOutput("t2_count", 32'(fifo_count), 0);
    checkOutput("t2_valid", 32'(cmd_valid), 0);
    checkOutput("t2_overflow", 32'(overflow), 0);
    @(posedge clk); #1;

    // T3: holdoff suppression, expiry, and a different command right behind
    idle(10);
    applyStimulus(8'h75, 1, 3'd2);
    idle(2);
    applyStimulus(8'h75, 0, 3'd2);
    idle(12);
    applyStimulus(8'h75, 1, 3'd2);
    applyStimulus(8'h72, 1, 3'd3);
    idle(2);
    @(negedge clk);
    checkOutput("t3_count", 32'(fifo_count), 3);
    @(posedge clk); #1;
    drain();

    // T4: overflow on a full queue, then clear
    applyStimulus(8'h1D, 1, 3'd0);
    applyStimulus(8'h1B, 1, 3'd1);
    applyStimulus(8'h1D, 1, 3'd0);
    applyStimulus(8'h1B, 1, 3'd1);
    applyStimulus(8'h1D, 0, 3'd0);
    idle(2);
    @(negedge clk);
    checkOutput("t4_count", 32'(fifo_count), 4);
    checkOutput("t4_overflow", 32'(overflow), 1);
    checkOutput("t4_head", 32'(cmd), 0);
    @(posedge clk); #1;
    clr_overflow = 1'b1;
    @(posedge clk); #1;
    clr_overflow = 1'b0;
    @(negedge clk);
    checkOutput("t4_clr", 32'(overflow), 0);
    checkOutput("t4_intact", 32'(fifo_count), 4);
    @(posedge clk); #1;

    // T5: push and pop on the same edge while full
    key_valid = 1'b1; key = 8'h75;
    @(posedge clk); #1;
    key_valid = 1'b0;
    cmd_ready = 1'b1;
    @(negedge clk);
    checkOutput("t5_head", 32'(cmd), 32'(sb.pop_front()));
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    sb.push_back(3'd2);
    @(negedge clk);
    checkOutput("t5_count", 32'(fifo_count), 4);
    checkOutput("t5_overflow", 32'(overflow), 0);
    @(posedge clk); #1;
    drain();

    // T6: reset with entries queued and a decode in flight
    applyStimulus(8'h72, 0, 3'd3);
    applyStimulus(8'h1D, 0, 3'd0);
    applyStimulus(8'h1B, 0, 3'd1);
    applyStimulus(8'h29, 0, 3'd4);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_pre_count", 32'(fifo_count), 3);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_count", 32'(fifo_count), 0);
    checkOutput("t6_valid", 32'(cmd_valid), 0);
    @(posedge clk); #1;
    idle(3);
    @(negedge clk);
    checkOutput("t6_no_ghost", 32'(cmd_valid), 0);
    @(posedge clk); #1;
    // last command was cleared by reset, so a repeat of 'S' is accepted at once
    applyStimulus(8'h1B, 1, 3'd1);
    idle(1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
